// File: rtl/act_unit_vec.sv
// act_unit_vec: LANES-wide 2-stage FP activation (relu/leaky/clamp/pass) with valid/ready in (act_*) and out (act_out_*), frame last/done, async reset
module act_unit_vec #(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16,
  localparam int DW = 1 + EXP_W + MAN_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [4:0]            leak_shift,
  input  logic [DW-1:0]         cap_value,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic [LANES*DW-1:0]   act_in,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic [LANES*DW-1:0]   act_out,
  output logic                  act_out_valid,
  input  logic                  act_out_ready,
  output logic                  act_last,
  output logic                  act_done
);
  function automatic logic [DW-1:0] act_f(input logic [DW-1:0] x, input logic [1:0] md,
                                          input logic [4:0] sh, input logic [DW-1:0] cap);
    logic s, emax, nan, flush;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [DW-1:0] leaky, clamp;
    s = x[DW-1];
    e = x[DW-2:MAN_W];
    m = x[MAN_W-1:0];
    emax = &e;
    nan = emax && m != '0;
    flush = 32'(e) <= 32'(sh);
    leaky = (!s || emax) ? x : flush ? '0 : {s, EXP_W'(32'(e) - 32'(sh)), m};
    clamp = s ? '0 : (x[DW-2:0] > cap[DW-2:0]) ? cap : x;
    return nan ? x : md == 2'd0 ? (s ? '0 : x) : md == 2'd1 ? leaky : md == 2'd2 ? clamp : x;
  endfunction
  logic en, in_hs, frame_active, last_tag, s1_valid, s1_last;
  logic [CNT_W-1:0] cnt, cfg_len, cur_len, in_len;
  logic [1:0] cfg_mode, cur_mode, s1_mode;
  logic [4:0] cfg_shift, cur_shift, s1_shift;
  logic [DW-1:0] cfg_cap, cur_cap, s1_cap;
  logic [LANES*DW-1:0] s1_data, result;
  assign en = !act_out_valid || act_out_ready;
  assign act_ready = en;
  assign in_hs = act_valid && en;
  assign in_len = (frame_len == '0) ? CNT_W'(1) : frame_len;
  // The first beat of a frame uses the live inputs; later beats use the latched copy.
  assign cur_mode = frame_active ? cfg_mode : mode;
  assign cur_shift = frame_active ? cfg_shift : leak_shift;
  assign cur_cap = frame_active ? cfg_cap : cap_value;
  assign cur_len = frame_active ? cfg_len : in_len;
  assign last_tag = cnt == cur_len - 1'b1;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      frame_active <= 1'b0;
      cnt <= '0;
      cfg_mode <= '0;
      cfg_shift <= '0;
      cfg_cap <= '0;
      cfg_len <= CNT_W'(1);
    end else if (in_hs) begin
      cfg_mode <= cur_mode;
      cfg_shift <= cur_shift;
      cfg_cap <= cur_cap;
      cfg_len <= cur_len;
      cnt <= last_tag ? '0 : cnt + 1'b1;
      frame_active <= !last_tag;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign result[i*DW +: DW] = act_f(s1_data[i*DW +: DW], s1_mode, s1_shift, s1_cap);
  end
  // S1 carries each beat with its own frame config so back-to-back frames never mix settings.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
      s1_mode <= '0;
      s1_shift <= '0;
      s1_cap <= '0;
      act_out_valid <= 1'b0;
      act_last <= 1'b0;
      act_out <= '0;
    end else if (en) begin
      s1_valid <= in_hs;
      s1_last <= in_hs && last_tag;
      s1_data <= act_in;
      s1_mode <= cur_mode;
      s1_shift <= cur_shift;
      s1_cap <= cur_cap;
      act_out_valid <= s1_valid;
      act_last <= s1_valid && s1_last;
      act_out <= s1_valid ? result : act_out;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) act_done <= 1'b0;
    else act_done <= act_out_valid && act_out_ready && act_last;
endmodule

// File: tb/tb_act_unit_vec.sv
// tb_act_unit_vec: directed + random bench for act_unit_vec with a field-level reference model and scoreboard
module tb_act_unit_vec;
  localparam int LANES = 4, EXP_W = 8, MAN_W = 23, CNT_W = 16, DW = 32, W = LANES * DW;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] mode = '0;
  logic [4:0] leak_shift = '0;
  logic [DW-1:0] cap_value = '0;
  logic [CNT_W-1:0] frame_len = '0;
  logic [W-1:0] act_in = '0, act_out;
  logic act_valid = 1'b0, act_ready, act_out_valid, act_out_ready = 1'b1, act_last, act_done;
  always #5 clock = ~clock;
  act_unit_vec #(.LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .mode(mode), .leak_shift(leak_shift), .cap_value(cap_value),
    .frame_len(frame_len), .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
    .act_out(act_out), .act_out_valid(act_out_valid), .act_out_ready(act_out_ready),
    .act_last(act_last), .act_done(act_done));
  int tests = 0, fails = 0;
  logic [W-1:0] q_data[$];
  logic q_last[$];
  logic m_active = 1'b0, done_exp = 1'b0, stall_prev = 1'b0, held_last = 1'b0;
  int m_cnt = 0, m_len = 1, m_mode = 0, m_shift = 0;
  logic [31:0] m_cap = '0;
  logic [W-1:0] held = '0;
  logic [31:0] pool [16] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00001, 32'hFFC00000, 32'h00400000, 32'h80400000,
                              32'h3F800000, 32'hBF800000, 32'hC1233333, 32'h42C04000,
                              32'h40C00000, 32'h3FCCCCCD, 32'hC2480000, 32'hBF400000};
  function automatic logic [31:0] ref_lane(logic [31:0] x, int md, int sh, logic [31:0] cap);
    int e;
    e = int'(x[30:23]);
    if (e == 255 && x[22:0] != 0) return x;
    case (md)
      0: return x[31] ? 32'h0 : x;
      1: begin
        if (!x[31] || e == 255) return x;
        if (e <= sh) return 32'h0;
        return {1'b1, 8'(e - sh), x[22:0]};
      end
      2: begin
        if (x[31]) return 32'h0;
        return (x[30:0] > cap[30:0]) ? cap : x;
      end
      default: return x;
    endcase
  endfunction
  function automatic logic [W-1:0] pack4(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    return {d, c, b, a};
  endfunction
  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    logic [31:0] p;
    for (int i = 0; i < LANES; i++) begin
      p = pool[$urandom_range(15)];
      case ($urandom_range(3))
        0: v[i*32 +: 32] = p;
        1: v[i*32 +: 32] = $urandom;
        2: v[i*32 +: 32] = {~p[31], p[30:0]};
        default: v[i*32 +: 32] = {1'($urandom_range(1)), 8'($urandom_range(12)), 23'($urandom)};
      endcase
    end
    return v;
  endfunction
  task automatic chk(input logic [W-1:0] obs, input logic [W-1:0] want, input string tag);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic model_push();
    logic [W-1:0] v;
    logic last;
    if (!m_active) begin
      m_mode = int'(mode);
      m_shift = int'(leak_shift);
      m_cap = cap_value;
      m_len = (frame_len == 0) ? 1 : int'(frame_len);
      m_active = 1'b1;
    end
    last = (m_cnt == m_len - 1);
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = ref_lane(act_in[i*32 +: 32], m_mode, m_shift, m_cap);
    q_data.push_back(v);
    q_last.push_back(last);
    if (last) begin
      m_cnt = 0;
      m_active = 1'b0;
    end else m_cnt++;
  endtask
  task automatic step();
    logic in_hs, out_hs, plast;
    logic [W-1:0] pd;
    @(negedge clock);
    in_hs = act_valid && act_ready;
    out_hs = act_out_valid && act_out_ready;
    plast = 1'b0;
    chk(W'(act_done), W'(done_exp), "done");
    chk(W'(act_ready), W'(!(act_out_valid && !act_out_ready)), "ready");
    if (stall_prev) begin
      chk(W'(act_out_valid), W'(1), "hold_valid");
      chk(act_out, held, "hold_data");
      chk(W'(act_last), W'(held_last), "hold_last");
    end
    stall_prev = act_out_valid && !act_out_ready;
    held = act_out;
    held_last = act_last;
    if (out_hs) begin
      if (q_data.size() == 0) chk(W'(act_out_valid), W'(0), "unexpected_beat");
      else begin
        pd = q_data.pop_front();
        plast = q_last.pop_front();
        chk(act_out, pd, "data");
        chk(W'(act_last), W'(plast), "last");
      end
    end
    if (in_hs) model_push();
    done_exp = plast;
    @(posedge clock);
    #1;
  endtask
  task automatic reset_now();
    reset = 1'b1;
    #1;
    chk(W'(act_out_valid), W'(0), "rst_valid");
    chk(W'(act_last), W'(0), "rst_last");
    chk(W'(act_done), W'(0), "rst_done");
    chk(act_out, W'(0), "rst_out");
    q_data.delete();
    q_last.delete();
    m_active = 1'b0;
    m_cnt = 0;
    done_exp = 1'b0;
    stall_prev = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask
  task automatic drain();
    act_valid = 1'b0;
    act_out_ready = 1'b1;
    for (int i = 0; i < 20 && q_data.size() != 0; i++) step();
    step();
    step();
    chk(W'(q_data.size()), W'(0), "drain");
  endtask
  task automatic send(input logic [W-1:0] v);
    act_valid = 1'b1;
    act_in = v;
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    reset_now();
    chk(W'(act_ready), W'(1), "rst_ready");
    mode = 2'd0;
    frame_len = 16'd3;
    send(pack4(32'hC1233333, 32'h7FC00001, 32'hBF800000, 32'h3F800000));
    act_valid = 1'b0;
    chk(W'(act_out_valid), W'(0), "latency1");
    step();
    chk(W'(act_out_valid), W'(1), "latency2");
    chk(W'(act_out[31:0]), W'(32'h00000000), "t1_lane0");
    send(pack4(32'h3FCCCCCD, 32'h7FC00001, 32'h80400000, 32'hFF800000));
    send(pack4(32'h80000000, 32'h7FC00001, 32'h00400000, 32'h7F800000));
    drain();
    mode = 2'd1;
    leak_shift = 5'd3;
    frame_len = 16'd5;
    send(pack4(32'hC1233333, 32'hBF800000, 32'h84000000, 32'h81800000));
    send(pack4(32'hBF400000, 32'h82000000, 32'h81800000, 32'h7FC00001));
    send(pack4(32'h80400000, 32'h80000000, 32'h3F800000, 32'hC2480000));
    send(pack4(32'hFF800000, 32'hFFC00000, 32'h83000000, 32'h00000000));
    send(pack4(32'h42C04000, 32'hC1233333, 32'hBF400000, 32'h80000001));
    drain();
    mode = 2'd2;
    cap_value = 32'h40C00000;
    frame_len = 16'd4;
    send(pack4(32'h42C04000, 32'h40C00000, 32'h40C00001, 32'h7FC00001));
    send(pack4(32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000));
    send(pack4(32'h3FCCCCCD, 32'h40BFFFFF, 32'h00400000, 32'h80400000));
    send(pack4(32'hC2480000, 32'h3F800000, 32'h42C04000, 32'hFFC00000));
    drain();
    mode = 2'd1;
    leak_shift = 5'd2;
    frame_len = 16'd8;
    act_out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      act_out_ready = !(c >= 4 && c < 8);
      send(rnd_vec());
    end
    drain();
    mode = 2'd0;
    frame_len = 16'd4;
    send(pack4(32'hBF800000, 32'hC1233333, 32'h3F800000, 32'hFF800000));
    mode = 2'd3;
    send(pack4(32'hBF800000, 32'h80400000, 32'h42C04000, 32'hC2480000));
    send(pack4(32'hBF400000, 32'h7F800000, 32'h80000000, 32'hBF800000));
    send(pack4(32'hC2480000, 32'hBF800000, 32'hBF800000, 32'hBF800000));
    frame_len = 16'd1;
    send(pack4(32'hBF800000, 32'hC1233333, 32'h80400000, 32'hFF800000));
    frame_len = 16'd0;
    mode = 2'd0;
    for (int c = 0; c < 3; c++) send(rnd_vec());
    drain();
    mode = 2'd0;
    frame_len = 16'd4;
    send(rnd_vec());
    send(rnd_vec());
    act_valid = 1'b0;
    #2;
    reset_now();
    frame_len = 16'd3;
    for (int c = 0; c < 3; c++) send(rnd_vec());
    drain();
    for (int c = 0; c < 400; c++) begin
      act_valid = $urandom_range(3) != 0;
      act_out_ready = $urandom_range(3) != 0;
      mode = 2'($urandom_range(3));
      leak_shift = 5'($urandom_range(31));
      cap_value = {1'b0, pool[$urandom_range(15)][30:0]};
      frame_len = 16'($urandom_range(6));
      act_in = rnd_vec();
      step();
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
